// File: rtl/eth_mac_tx_arb.sv
// Frame-level round-robin arbiter feeding the MAC tx_axis port from S_COUNT requesters.
// A grant is held from the first beat to the accepted tlast beat; the output beat is registered.
module eth_mac_tx_arb #(
   parameter int S_COUNT   = 4,
   parameter int IDX_WIDTH = $clog2(S_COUNT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*S_COUNT-1:0]   s_axis_tdata,
   input  logic [S_COUNT-1:0]     s_axis_tvalid,
   output logic [S_COUNT-1:0]     s_axis_tready,
   input  logic [S_COUNT-1:0]     s_axis_tlast,
   input  logic [S_COUNT-1:0]     s_axis_tuser,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   input  logic [S_COUNT-1:0]     port_enable,
   output logic                   grant_valid,
   output logic [IDX_WIDTH-1:0]   grant_index,
   output logic                   frame_done
);

   // All streams are AXI valid/ready: a beat moves on a cycle where both are high,
   // valid never depends on ready, and a presented beat holds until it moves.
   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [IDX_WIDTH-1:0] last_grant_q, last_grant_d;
   logic [IDX_WIDTH-1:0] grant_index_q, grant_index_d;
   logic [7:0]           m_tdata_q, m_tdata_d;
   logic                 m_tvalid_q, m_tvalid_d;
   logic                 m_tlast_q, m_tlast_d;
   logic                 m_tuser_q, m_tuser_d;
   logic                 frame_done_q, frame_done_d;

   logic [S_COUNT-1:0]   req;
   logic [IDX_WIDTH-1:0] hi_pick, lo_pick, rr_pick;
   logic                 hi_found;
   logic [7:0]           in_data;
   logic                 in_valid, in_last, in_user, in_ready, in_fire;

   assign req = s_axis_tvalid & port_enable;

   // Prefer the lowest requester above last_grant, else wrap to the lowest overall.
   always_comb begin : rr_search
      hi_found = 1'b0;
      hi_pick  = '0;
      lo_pick  = '0;
      for (int j = S_COUNT - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_pick = IDX_WIDTH'(j);
            if (j > int'(last_grant_q)) begin
               hi_found = 1'b1;
               hi_pick  = IDX_WIDTH'(j);
            end
         end
      end
      rr_pick = hi_found ? hi_pick : lo_pick;
   end

   always_comb begin : grant_mux
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_user  = 1'b0;
      for (int p = 0; p < S_COUNT; p++) begin
         if (grant_index_q == IDX_WIDTH'(p)) begin
            in_data  = s_axis_tdata[8*p +: 8];
            in_valid = s_axis_tvalid[p];
            in_last  = s_axis_tlast[p];
            in_user  = s_axis_tuser[p];
         end
      end
   end

   assign in_ready = (state_q == ACTIVE) && (!m_tvalid_q || m_axis_tready);
   assign in_fire  = in_ready && in_valid;

   always_comb begin : tready_decode
      s_axis_tready = '0;
      for (int p = 0; p < S_COUNT; p++) begin
         s_axis_tready[p] = in_ready && (grant_index_q == IDX_WIDTH'(p));
      end
   end

   always_comb begin : next_state
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_index_d = grant_index_q;
      m_tdata_d     = m_tdata_q;
      m_tvalid_d    = m_tvalid_q;
      m_tlast_d     = m_tlast_q;
      m_tuser_d     = m_tuser_q;
      frame_done_d  = 1'b0;

      if (in_fire) begin
         m_tdata_d  = in_data;
         m_tlast_d  = in_last;
         m_tuser_d  = in_user;
         m_tvalid_d = 1'b1;
      end else if (m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (req != '0) begin
               grant_index_d = rr_pick;
               state_d       = ACTIVE;
            end
         end
         ACTIVE: begin
            // Going back through IDLE forces one dead input cycle between frames.
            if (in_fire && in_last) begin
               frame_done_d = 1'b1;
               last_grant_d = grant_index_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_grant_q  <= IDX_WIDTH'(S_COUNT - 1);
         grant_index_q <= '0;
         m_tdata_q     <= '0;
         m_tvalid_q    <= 1'b0;
         m_tlast_q     <= 1'b0;
         m_tuser_q     <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_index_q <= grant_index_d;
         m_tdata_q     <= m_tdata_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tlast_q     <= m_tlast_d;
         m_tuser_q     <= m_tuser_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;
   assign m_axis_tuser  = m_tuser_q;
   assign grant_valid   = (state_q == ACTIVE);
   assign grant_index   = grant_index_q;
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_eth_mac_tx_arb.sv
// Bench for eth_mac_tx_arb: AXI sources, per-cycle behavioural model, beat scoreboard,
// and directed scenarios followed by a randomized soak.
module tb_eth_mac_tx_arb;
   localparam int S  = 4;
   localparam int IW = $clog2(S);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [8*S-1:0]  s_tdata = '0;
   logic [S-1:0]    s_tvalid = '0;
   logic [S-1:0]    s_tready;
   logic [S-1:0]    s_tlast = '0;
   logic [S-1:0]    s_tuser = '0;
   logic [7:0]      m_tdata;
   logic            m_tvalid;
   logic            m_tready = 1'b1;
   logic            m_tlast;
   logic            m_tuser;
   logic [S-1:0]    port_en = '1;
   logic            grant_valid;
   logic [IW-1:0]   grant_index;
   logic            frame_done;

   eth_mac_tx_arb #(.S_COUNT(S)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .port_enable(port_en), .grant_valid(grant_valid), .grant_index(grant_index),
      .frame_done(frame_done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- sources (beat = {data, last, user}) ----------------
   logic [9:0]   src_q [S][$];
   logic [S-1:0] hs_sample = '0;
   int           valid_pct = 100;
   int           rdy_mode = 0;

   initial begin
      forever begin
         @(posedge clk); #1;
         for (int p = 0; p < S; p++) begin
            if (hs_sample[p]) begin
               if (src_q[p].size() != 0) void'(src_q[p].pop_front());
               s_tvalid[p] = 1'b0;
            end
            if (!s_tvalid[p] && src_q[p].size() != 0 && $urandom_range(0, 99) < valid_pct)
               s_tvalid[p] = 1'b1;
            if (s_tvalid[p]) begin
               s_tdata[8*p +: 8] = src_q[p][0][9:2];
               s_tlast[p]        = src_q[p][0][1];
               s_tuser[p]        = src_q[p][0][0];
            end
         end
         if (rdy_mode == 1) m_tready = ($urandom_range(0, 99) < 70);
      end
   end

   task automatic push_frame(input int p, input int len, input int base, input logic user_last);
      logic [9:0] b;
      for (int i = 0; i < len; i++) begin
         b = {8'(base + i), (i == len - 1), (i == len - 1) ? user_last : 1'b0};
         src_q[p].push_back(b);
      end
   endtask

   task automatic push_rand_frame(input int p, input int len);
      logic [9:0] b;
      for (int i = 0; i < len; i++) begin
         b = {8'($urandom_range(0, 255)), (i == len - 1), 1'b0};
         if (i == len - 1) b[0] = 1'($urandom_range(0, 1));
         src_q[p].push_back(b);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         mdl_live = 0;
   bit         mdl_busy;
   int         mdl_owner;
   int         mdl_last;
   bit         mdl_fd;
   logic [9:0] mdl_slot[$];
   logic [9:0] exp_q[$];
   bit         mdl_acc;
   logic [9:0] mdl_beat;

   // Requester closest after the last winner, counting upward with wrap.
   function automatic int rr_pick(input logic [S-1:0] req, input int last);
      int best, best_d, d;
      best = -1;
      best_d = S + 1;
      for (int p = 0; p < S; p++) begin
         d = (p - last - 1 + 2 * S) % S;
         if (req[p] && d < best_d) begin
            best_d = d;
            best = p;
         end
      end
      return best;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mdl_live = 1;
         mdl_busy = 0;
         mdl_owner = 0;
         mdl_last = S - 1;
         mdl_fd = 0;
         mdl_slot.delete();
         exp_q.delete();
      end else if (mdl_live) begin
         mdl_acc = mdl_busy && s_tvalid[mdl_owner] && (mdl_slot.size() == 0 || m_tready);
         if (mdl_slot.size() != 0 && m_tready) void'(mdl_slot.pop_front());
         mdl_fd = 0;
         if (mdl_acc) begin
            mdl_beat = {s_tdata[8*mdl_owner +: 8], s_tlast[mdl_owner], s_tuser[mdl_owner]};
            mdl_slot.push_back(mdl_beat);
            exp_q.push_back(mdl_beat);
            if (mdl_beat[1]) begin
               mdl_fd = 1;
               mdl_busy = 0;
               mdl_last = mdl_owner;
            end
         end else if (!mdl_busy && (s_tvalid & port_en) != '0) begin
            mdl_owner = rr_pick(s_tvalid & port_en, mdl_last);
            mdl_busy = 1;
         end
      end
   end

   // ---------------- compare + monitor ----------------
   logic [9:0] out_log[$];
   int         grant_log[$];
   int         grant_cyc[$];
   int         acc_cyc[$];
   bit         acc_last[$];
   int         fd_cnt = 0;
   int         tv_first = -1;
   bit         gv_prev = 0;
   logic [S-1:0] exp_rdy;

   always @(negedge clk) begin
      if (mdl_live) begin
         exp_rdy = '0;
         if (mdl_busy && (mdl_slot.size() == 0 || m_tready)) exp_rdy[mdl_owner] = 1'b1;
         check("s_tready", 32'(s_tready), 32'(exp_rdy));
         check("m_tvalid", 32'(m_tvalid), 32'(mdl_slot.size() != 0));
         if (mdl_slot.size() != 0) check("m_beat", 32'({m_tdata, m_tlast, m_tuser}), 32'(mdl_slot[0]));
         check("grant_valid", 32'(grant_valid), 32'(mdl_busy));
         check("grant_index", 32'(grant_index), mdl_owner);
         check("frame_done", 32'(frame_done), 32'(mdl_fd));
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) check("sb_extra_beat", 32'({m_tdata, m_tlast, m_tuser}), 32'hFFFF);
            else check("sb_beat", 32'({m_tdata, m_tlast, m_tuser}), 32'(exp_q.pop_front()));
            out_log.push_back({m_tdata, m_tlast, m_tuser});
         end
      end
      hs_sample = s_tvalid & s_tready;
      if (hs_sample != '0) begin
         acc_cyc.push_back(cyc);
         acc_last.push_back((hs_sample & s_tlast) != '0);
      end
      if (grant_valid && !gv_prev) begin
         grant_log.push_back(int'(grant_index));
         grant_cyc.push_back(cyc);
      end
      gv_prev = grant_valid;
      if (frame_done) fd_cnt++;
      if (tv_first < 0 && s_tvalid != '0) tv_first = cyc;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic nsync();
      @(negedge clk); #1;
   endtask

   task automatic flush_sources();
      for (int p = 0; p < S; p++) src_q[p].delete();
      s_tvalid = '0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      flush_sources();
      tick();
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      out_log.delete();
      grant_log.delete();
      grant_cyc.delete();
      acc_cyc.delete();
      acc_last.delete();
      fd_cnt = 0;
      tv_first = -1;
   endtask

   task automatic wait_fd(input int n, input int limit, input string name);
      int g = 0;
      while (fd_cnt < n && g < limit) begin
         nsync();
         g++;
      end
      if (fd_cnt < n) check(name, fd_cnt, n);
   endtask

   function automatic int glog(input int i);
      return (i < grant_log.size()) ? grant_log[i] : -1;
   endfunction

   function automatic logic [9:0] olog(input int i);
      return (i < out_log.size()) ? out_log[i] : 10'h3FF;
   endfunction

   // ---------------- scenarios ----------------
   initial begin
      int exp_g[8];
      int total;
      int g;
      bit drained;

      repeat (3) tick();
      rst = 1'b0;

      // 1: single 64-byte frame from port 2
      do_reset(); clear_logs();
      rdy_mode = 0; m_tready = 1'b1; valid_pct = 100; port_en = '1;
      nsync();
      push_frame(2, 64, 0, 1'b0);
      wait_fd(1, 300, "t1_timeout");
      repeat (3) nsync();
      check("t1_grant_idx", glog(0), 2);
      check("t1_grant_lat", (grant_cyc.size() > 0) ? grant_cyc[0] - tv_first : -1, 1);
      check("t1_nbytes", out_log.size(), 64);
      for (int i = 0; i < 64; i++) check("t1_byte", 32'(olog(i)), 32'({8'(i), (i == 63), 1'b0}));
      check("t1_fd_count", fd_cnt, 1);
      check("t1_idle", 32'(grant_valid), 0);

      // 2: fairness, four ports with two 3-byte frames each
      do_reset(); clear_logs();
      nsync();
      for (int f = 0; f < 2; f++)
         for (int p = 0; p < S; p++) push_frame(p, 3, p * 16 + f * 4, 1'b0);
      wait_fd(8, 400, "t2_timeout");
      repeat (3) nsync();
      exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int k = 0; k < 8; k++) check("t2_grant_order", glog(k), exp_g[k]);
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 3; j++)
            check("t2_frame_beat", 32'(olog(3 * k + j)),
                  32'({8'((k % 4) * 16 + (k / 4) * 4 + j), (j == 2), 1'b0}));
      for (int i = 1; i < acc_cyc.size(); i++)
         check("t2_input_gap", acc_cyc[i] - acc_cyc[i-1], acc_last[i-1] ? 2 : 1);

      // 3: output backpressure for 5 cycles inside a 60-byte frame
      do_reset(); clear_logs();
      nsync();
      push_frame(1, 60, 0, 1'b0);
      g = 0;
      while (out_log.size() < 20 && g < 200) begin nsync(); g++; end
      check("t3_reach_20", 32'(out_log.size() >= 20), 1);
      tick();
      m_tready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         nsync();
         check("t3_hold_valid", 32'(m_tvalid), 1);
         check("t3_hold_beat", 32'({m_tdata, m_tlast, m_tuser}), 32'({8'(out_log.size()), 2'b00}));
         check("t3_tready_low", 32'(s_tready), 0);
      end
      tick();
      m_tready = 1'b1;
      wait_fd(1, 300, "t3_timeout");
      check("t3_nbytes", out_log.size(), 60);
      for (int i = 0; i < 60; i++) check("t3_byte", 32'(olog(i)), 32'({8'(i), (i == 59), 1'b0}));

      // 4: enable mask 1010, then drop port 1 mid-frame
      do_reset(); clear_logs();
      port_en = 4'b1010;
      nsync();
      for (int f = 0; f < 3; f++)
         for (int p = 0; p < S; p++) push_frame(p, 4, p * 16 + f * 4, 1'b0);
      g = 0;
      while (grant_log.size() < 3 && g < 200) begin nsync(); g++; end
      check("t4_third_grant", glog(2), 1);
      tick();
      port_en = 4'b1000;
      wait_fd(5, 400, "t4_timeout");
      repeat (20) nsync();
      check("t4_ngrants", grant_log.size(), 5);
      check("t4_g0", glog(0), 1);
      check("t4_g1", glog(1), 3);
      check("t4_g2", glog(2), 1);
      check("t4_g3", glog(3), 3);
      check("t4_g4", glog(4), 3);
      for (int j = 0; j < 4; j++) check("t4_cut_frame", 32'(olog(8 + j)), 32'({8'(8'h14 + j), (j == 3), 1'b0}));
      check("t4_fd_count", fd_cnt, 5);
      port_en = '1;

      // 5: single-beat error frame, then back-to-back single beats from port 0
      do_reset(); clear_logs();
      nsync();
      push_frame(0, 1, 8'hA5, 1'b1);
      wait_fd(1, 50, "t5a_timeout");
      nsync();
      check("t5_err_beat", 32'(olog(0)), 32'({8'hA5, 1'b1, 1'b1}));
      clear_logs();
      for (int i = 0; i < 4; i++) push_frame(0, 1, 8'h10 + i, 1'b0);
      wait_fd(4, 100, "t5b_timeout");
      nsync();
      for (int i = 0; i < 4; i++) check("t5_single", 32'(olog(i)), 32'({8'(8'h10 + i), 1'b1, 1'b0}));
      for (int i = 1; i < acc_cyc.size(); i++) check("t5_every_2nd", acc_cyc[i] - acc_cyc[i-1], 2);

      // 6: reset during byte 10 of a port-1 frame
      do_reset(); clear_logs();
      nsync();
      push_frame(1, 30, 0, 1'b0);
      g = 0;
      while (acc_cyc.size() < 10 && g < 100) begin nsync(); g++; end
      check("t6_reach_10", 32'(acc_cyc.size() >= 10), 1);
      tick();
      rst = 1'b1;
      flush_sources();
      tick();
      rst = 1'b0;
      nsync();
      check("t6_m_tvalid", 32'(m_tvalid), 0);
      check("t6_grant_valid", 32'(grant_valid), 0);
      check("t6_tready", 32'(s_tready), 0);
      clear_logs();
      push_frame(1, 5, 8'h40, 1'b0);
      push_frame(0, 5, 8'h80, 1'b0);
      wait_fd(2, 100, "t6_timeout");
      check("t6_first_grant", glog(0), 0);
      check("t6_second_grant", glog(1), 1);
      check("t6_first_byte", 32'(olog(0)), 32'({8'h80, 2'b00}));

      // 7: randomized soak with random tvalid, tready and enables
      do_reset(); clear_logs();
      rdy_mode = 1; valid_pct = 60; total = 0;
      nsync();
      for (int p = 0; p < S; p++)
         for (int f = 0; f < 6; f++) begin
            push_rand_frame(p, $urandom_range(1, 8));
            total++;
         end
      drained = 0;
      for (int c = 0; c < 4000 && !drained; c++) begin
         nsync();
         if (c % 40 == 0) port_en = (c < 1500) ? 4'($urandom_range(0, 15)) : 4'hF;
         drained = !mdl_busy && mdl_slot.size() == 0;
         for (int p = 0; p < S; p++) if (src_q[p].size() != 0) drained = 0;
      end
      repeat (5) nsync();
      check("t7_drained", 32'(drained), 1);
      check("t7_fd_count", fd_cnt, total);
      check("t7_sb_empty", exp_q.size(), 0);
      rdy_mode = 0; m_tready = 1'b1; port_en = '1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
